// File: rtl/gate_stim_pkg.sv
// Purpose: state encoding and constants shared by the gate stimulus sequencer files.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gate_stim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DWELL   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic       MODE_MANUAL = 1'b0;
  localparam logic       MODE_AUTO   = 1'b1;
  localparam logic [1:0] LAST_IDX    = 2'd3;

endpackage

// File: rtl/gate_switch_debounce.sv
// Purpose: two-flop synchroniser plus stability counter for one raw board switch.
// Latency: a raw level stable for DEBOUNCE_CYCLES+2 cycles appears on db_out.
// Backpressure: none; runs every cycle regardless of what consumes db_out.
module gate_switch_debounce
  import gate_stim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic raw_in,
  output logic db_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             cand_q;
  logic             db_q;
  logic             db_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Stability count: restart on any change of the synced level, saturate at the last count,
  // and promote the synced level the moment the count lands on the last value.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_LAST) begin
      db_d = sync2_q;
    end
  end

  // Synchroniser, candidate and debounced registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_out = db_q;

endmodule

// File: rtl/gate_stim_sequencer.sv
// Purpose: drives the a/b operand pair of the gate block (AUTO truth-table sweep or MANUAL switches).
// Latency: start to first valid 1 cycle; accept to next valid DWELL_CYCLES+1 cycles.
// Backpressure: a pattern is held with valid_out high until ready_in; ready_in while idle is ignored.
module gate_stim_sequencer
  import gate_stim_pkg::*;
#(
  parameter int DWELL_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       mode_in,
  input  logic       start_in,
  input  logic       sw_a_in,
  input  logic       sw_b_in,
  input  logic       ready_in,
  output logic       a_out,
  output logic       b_out,
  output logic       valid_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [1:0] idx_out
);

  // The dwell state spans DWELL_CYCLES hold cycles plus the cycle that hands over to the
  // next pattern, so the counter runs 0..DWELL_CYCLES and stops there.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES);

  state_e           state_q;
  logic             auto_q;
  logic [1:0]       idx_q;
  logic             a_q;
  logic             b_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] dwell_q;
  logic             sw_a_db;
  logic             sw_b_db;

  gate_switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_a (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .raw_in (sw_a_in),
    .db_out (sw_a_db)
  );

  gate_switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .raw_in (sw_b_in),
    .db_out (sw_b_db)
  );

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      auto_q  <= 1'b0;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mode_in == MODE_AUTO) begin
            if (start_in) begin
              auto_q  <= 1'b1;
              idx_q   <= 2'd0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= PRESENT;
            end
          end else if ({sw_a_db, sw_b_db} != {a_q, b_q}) begin
            auto_q  <= 1'b0;
            a_q     <= sw_a_db;
            b_q     <= sw_b_db;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            if (auto_q) begin
              dwell_q <= '0;
              state_q <= DWELL;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        DWELL: begin
          if (dwell_q == DWELL_LAST) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q        <= idx_q + 2'd1;
              {a_q, b_q}   <= idx_q + 2'd1;
              valid_q      <= 1'b1;
              state_q      <= PRESENT;
            end
          end else begin
            dwell_q <= dwell_q + CNT_W'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign idx_out   = idx_q;

endmodule
